// File: rtl/camac_dataway_cycle_gen.sv
// Single CAMAC dataway cycle generator: one valid/ready command -> fixed-timing NAF/B/S1/S2 cycle -> Q/X/read-data response.
// Define CAMAC_NEG_LOGIC_EN for a negative-logic dataway (camac_* outputs and camac_r/q/x inverted, camac_w_oe unchanged).
module camac_dataway_cycle_gen #(
  parameter int unsigned SETUP_CLKS = 20,
  parameter int unsigned S1_CLKS    = 5,
  parameter int unsigned GAP_CLKS   = 5,
  parameter int unsigned S2_CLKS    = 5,
  parameter int unsigned HOLD_CLKS  = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [4:0]  cmd_n,
  input  logic [3:0]  cmd_a,
  input  logic [4:0]  cmd_f,
  input  logic [23:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [23:0] rsp_rdata,
  output logic        rsp_q,
  output logic        rsp_x,
  output logic        rsp_err,
  output logic [23:0] camac_n,
  output logic [3:0]  camac_a,
  output logic [4:0]  camac_f,
  output logic        camac_b,
  output logic        camac_s1,
  output logic        camac_s2,
  output logic [23:0] camac_w,
  output logic        camac_w_oe,
  input  logic [23:0] camac_r,
  input  logic        camac_q,
  input  logic        camac_x
);

  localparam int unsigned MAX_01  = (SETUP_CLKS > S1_CLKS) ? SETUP_CLKS : S1_CLKS;
  localparam int unsigned MAX_012 = (MAX_01 > GAP_CLKS) ? MAX_01 : GAP_CLKS;
  localparam int unsigned MAX_03  = (MAX_012 > S2_CLKS) ? MAX_012 : S2_CLKS;
  localparam int unsigned MAX_CLKS = (MAX_03 > HOLD_CLKS) ? MAX_03 : HOLD_CLKS;
  localparam int unsigned CNT_W   = (MAX_CLKS > 1) ? $clog2(MAX_CLKS) : 1;
  localparam int unsigned DW      = 24;

`ifdef CAMAC_NEG_LOGIC_EN
  localparam logic NEG = 1'b1;
`else
  localparam logic NEG = 1'b0;
`endif

  if (SETUP_CLKS < 1 || S1_CLKS < 1 || GAP_CLKS < 1 || S2_CLKS < 1 || HOLD_CLKS < 1) begin : g_bad_param
    $error("camac_dataway_cycle_gen: every stage length must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_STB1, S_GAP, S_STB2, S_HOLD, S_RESP
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Latched command
  logic [4:0]    n_q, n_d;
  logic [3:0]    a_q, a_d;
  logic [4:0]    f_q, f_d;
  logic [DW-1:0] wdata_q, wdata_d;

  // Dataway inputs captured at the end of S1 (logical polarity)
  logic [DW-1:0] smp_r_q, smp_r_d;
  logic          smp_q_q, smp_q_d;
  logic          smp_x_q, smp_x_d;

  logic          cmd_ready_q, cmd_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic          rsp_q_q, rsp_q_d;
  logic          rsp_x_q, rsp_x_d;
  logic          rsp_err_q, rsp_err_d;

  // Dataway outputs stored at their physical level
  logic [DW-1:0] camac_n_q, camac_n_d;
  logic [3:0]    camac_a_q, camac_a_d;
  logic [4:0]    camac_f_q, camac_f_d;
  logic          camac_b_q, camac_b_d;
  logic          camac_s1_q, camac_s1_d;
  logic          camac_s2_q, camac_s2_d;
  logic [DW-1:0] camac_w_q, camac_w_d;
  logic          camac_w_oe_q, camac_w_oe_d;

  logic          active;
  logic          legal_n;
  logic          is_read;
  logic          is_write;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    n_d          = n_q;
    a_d          = a_q;
    f_d          = f_q;
    wdata_d      = wdata_q;
    smp_r_d      = smp_r_q;
    smp_q_d      = smp_q_q;
    smp_x_d      = smp_x_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_q_d      = rsp_q_q;
    rsp_x_d      = rsp_x_q;
    rsp_err_d    = rsp_err_q;
    active       = 1'b0;
    legal_n      = 1'b0;
    is_read      = 1'b0;
    is_write     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          n_d     = cmd_n;
          a_d     = cmd_a;
          f_d     = cmd_f;
          wdata_d = cmd_wdata;
          if (cmd_n >= 5'd1 && cmd_n <= 5'd24) begin
            state_d = S_SETUP;
            cnt_d   = CNT_W'(SETUP_CLKS - 1);
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_STB1;
          cnt_d   = CNT_W'(S1_CLKS - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_STB1: begin
        // Q/X/R are taken on the edge that closes the last S1 cycle
        if (cnt_q == '0) begin
          state_d = S_GAP;
          cnt_d   = CNT_W'(GAP_CLKS - 1);
          smp_q_d = camac_q ^ NEG;
          smp_x_d = camac_x ^ NEG;
          smp_r_d = (f_q[4:3] == 2'b00) ? (camac_r ^ {DW{NEG}}) : '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          state_d = S_STB2;
          cnt_d   = CNT_W'(S2_CLKS - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_STB2: begin
        if (cnt_q == '0) begin
          state_d = S_HOLD;
          cnt_d   = CNT_W'(HOLD_CLKS - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          state_d = S_RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Registered outputs follow the state being entered
    active   = (state_d == S_SETUP) || (state_d == S_STB1) || (state_d == S_GAP) ||
               (state_d == S_STB2)  || (state_d == S_HOLD);
    legal_n  = (n_d >= 5'd1) && (n_d <= 5'd24);
    is_read  = (f_d[4:3] == 2'b00);
    is_write = (f_d[4:3] == 2'b10);

    camac_b_d    = active ^ NEG;
    camac_s1_d   = (state_d == S_STB1) ^ NEG;
    camac_s2_d   = (state_d == S_STB2) ^ NEG;
    camac_n_d    = (active ? (DW'(1) << (n_d - 5'd1)) : '0) ^ {DW{NEG}};
    camac_a_d    = (active ? a_d : 4'h0) ^ {4{NEG}};
    camac_f_d    = (active ? f_d : 5'h0) ^ {5{NEG}};
    camac_w_d    = ((active && is_write) ? wdata_d : '0) ^ {DW{NEG}};
    camac_w_oe_d = active && is_write;

    cmd_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP);

    // Response fields change only when a response is issued
    if (state_d == S_RESP) begin
      rsp_err_d   = !legal_n;
      rsp_q_d     = legal_n && smp_q_q;
      rsp_x_d     = legal_n && smp_x_q;
      rsp_rdata_d = (legal_n && is_read) ? smp_r_q : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      n_q          <= '0;
      a_q          <= '0;
      f_q          <= '0;
      wdata_q      <= '0;
      smp_r_q      <= '0;
      smp_q_q      <= 1'b0;
      smp_x_q      <= 1'b0;
      cmd_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_q_q      <= 1'b0;
      rsp_x_q      <= 1'b0;
      rsp_err_q    <= 1'b0;
      camac_n_q    <= {DW{NEG}};
      camac_a_q    <= {4{NEG}};
      camac_f_q    <= {5{NEG}};
      camac_b_q    <= NEG;
      camac_s1_q   <= NEG;
      camac_s2_q   <= NEG;
      camac_w_q    <= {DW{NEG}};
      camac_w_oe_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      n_q          <= n_d;
      a_q          <= a_d;
      f_q          <= f_d;
      wdata_q      <= wdata_d;
      smp_r_q      <= smp_r_d;
      smp_q_q      <= smp_q_d;
      smp_x_q      <= smp_x_d;
      cmd_ready_q  <= cmd_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_q_q      <= rsp_q_d;
      rsp_x_q      <= rsp_x_d;
      rsp_err_q    <= rsp_err_d;
      camac_n_q    <= camac_n_d;
      camac_a_q    <= camac_a_d;
      camac_f_q    <= camac_f_d;
      camac_b_q    <= camac_b_d;
      camac_s1_q   <= camac_s1_d;
      camac_s2_q   <= camac_s2_d;
      camac_w_q    <= camac_w_d;
      camac_w_oe_q <= camac_w_oe_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_q      = rsp_q_q;
  assign rsp_x      = rsp_x_q;
  assign rsp_err    = rsp_err_q;
  assign camac_n    = camac_n_q;
  assign camac_a    = camac_a_q;
  assign camac_f    = camac_f_q;
  assign camac_b    = camac_b_q;
  assign camac_s1   = camac_s1_q;
  assign camac_s2   = camac_s2_q;
  assign camac_w    = camac_w_q;
  assign camac_w_oe = camac_w_oe_q;

endmodule

// File: tb/tb_camac_dataway_cycle_gen.sv
// Bench for camac_dataway_cycle_gen: table vectors, random commands against a cycle-timeline model, reset and back-to-back sequences.
module tb_camac_dataway_cycle_gen;

  localparam int SETUP = 20;
  localparam int S1    = 5;
  localparam int GAP   = 5;
  localparam int S2    = 5;
  localparam int HOLD  = 15;
  localparam int T_S1  = SETUP;
  localparam int T_S2  = SETUP + S1 + GAP;
  localparam int T_END = SETUP + S1 + GAP + S2 + HOLD;
  localparam int T_SMP = SETUP + S1 - 1;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [4:0]  cmd_n;
  logic [3:0]  cmd_a;
  logic [4:0]  cmd_f;
  logic [23:0] cmd_wdata;
  logic        rsp_valid;
  logic [23:0] rsp_rdata;
  logic        rsp_q;
  logic        rsp_x;
  logic        rsp_err;
  logic [23:0] camac_n;
  logic [3:0]  camac_a;
  logic [4:0]  camac_f;
  logic        camac_b;
  logic        camac_s1;
  logic        camac_s2;
  logic [23:0] camac_w;
  logic        camac_w_oe;
  logic [23:0] camac_r;
  logic        camac_q;
  logic        camac_x;

  int total;
  int bad;

  camac_dataway_cycle_gen dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_n(cmd_n), .cmd_a(cmd_a), .cmd_f(cmd_f), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_q(rsp_q), .rsp_x(rsp_x), .rsp_err(rsp_err),
    .camac_n(camac_n), .camac_a(camac_a), .camac_f(camac_f),
    .camac_b(camac_b), .camac_s1(camac_s1), .camac_s2(camac_s2),
    .camac_w(camac_w), .camac_w_oe(camac_w_oe),
    .camac_r(camac_r), .camac_q(camac_q), .camac_x(camac_x)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog sim_time=%0t limit=1000000", $time);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [4:0]  n;
    logic [3:0]  a;
    logic [4:0]  f;
    logic [23:0] wd;
    logic [23:0] r;
    logic        q;
    logic        x;
    logic [26:0] rsp;  // {rdata, q, x, err}
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] dut_vec();
    return {1'b0, camac_b, camac_s1, camac_s2, camac_w_oe, camac_n, camac_a, camac_f,
            camac_w, cmd_ready, rsp_valid};
  endfunction

  function automatic logic [26:0] rsp_pack();
    return {rsp_rdata, rsp_q, rsp_x, rsp_err};
  endfunction

  // Expected dataway/handshake picture k cycles after the accept edge
  function automatic logic [63:0] exp_vec(int k, bit legal, logic [4:0] n, logic [3:0] a,
                                          logic [4:0] f, logic [23:0] w);
    bit act, wr, s1, s2;
    int endk;
    logic [23:0] oh;
    endk = legal ? T_END : 0;
    act  = legal && (k < T_END);
    wr   = (f[4:3] == 2'b10);
    s1   = legal && (k >= T_S1) && (k < T_S1 + S1);
    s2   = legal && (k >= T_S2) && (k < T_S2 + S2);
    oh   = '0;
    if (act) oh[int'(n) - 1] = 1'b1;
    return {1'b0, act, s1, s2, act && wr, oh, act ? a : 4'h0, act ? f : 5'h0,
            (act && wr) ? w : 24'h0, k > endk, k == endk};
  endfunction

  function automatic logic [26:0] ref_rsp(logic [4:0] n, logic [4:0] f, logic [23:0] r,
                                          logic q, logic x);
    if (n == 5'd0 || n > 5'd24) return {24'h0, 1'b0, 1'b0, 1'b1};
    return {(f[4:3] == 2'b00) ? r : 24'h0, q, x, 1'b0};
  endfunction

  task automatic wait_ready(output bit ok);
    int w;
    w  = 0;
    ok = 1'b1;
    while (cmd_ready !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (cmd_ready !== 1'b1) begin
      total++;
      bad++;
      ok = 1'b0;
      $display("FAIL accept_wait cmd_ready=%b expected=1", cmd_ready);
    end
  endtask

  // Issue one command and check the bus every cycle until one cycle past the response
  task automatic do_cmd(input logic [4:0] n, input logic [3:0] a, input logic [4:0] f,
                        input logic [23:0] wd, input logic [23:0] r, input logic q, input logic x,
                        output logic [26:0] rsp_at, output logic [26:0] rsp_hold);
    bit legal, ok;
    int endk;
    legal    = (n >= 5'd1) && (n <= 5'd24);
    endk     = legal ? T_END : 0;
    rsp_at   = '0;
    rsp_hold = '0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_n = n; cmd_a = a; cmd_f = f; cmd_wdata = wd;
    wait_ready(ok);
    if (!ok) begin
      cmd_valid = 1'b0;
      return;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_n = 5'($urandom); cmd_a = 4'($urandom); cmd_f = 5'($urandom); cmd_wdata = 24'($urandom);
    for (int k = 0; k <= endk + 1; k++) begin
      chk($sformatf("bus n=%0d f=%0d k=%0d", n, f, k), dut_vec(), exp_vec(k, legal, n, a, f, wd));
      if (k == endk)     rsp_at   = rsp_pack();
      if (k == endk + 1) rsp_hold = rsp_pack();
      camac_r = (k == T_SMP) ? r : 24'($urandom);
      camac_q = (k == T_SMP) ? q : 1'($urandom);
      camac_x = (k == T_SMP) ? x : 1'($urandom);
      if (k <= endk) @(negedge clk);
    end
  endtask

  initial begin
    logic [26:0] got, hold, e;
    logic [4:0]  rn, rf;
    logic [3:0]  ra;
    logic [23:0] rwd, rr;
    logic        rq, rx;
    bit          ok;
    int          cnt;

    total = 0;
    bad   = 0;
    rst_n = 1'b1;
    cmd_valid = 1'b0; cmd_n = '0; cmd_a = '0; cmd_f = '0; cmd_wdata = '0;
    camac_r = '0; camac_q = 1'b0; camac_x = 1'b0;

    tbl[0] = '{5'd5,  4'd2,  5'd0,  24'h000000, 24'hA5A5A5, 1'b1, 1'b1, {24'hA5A5A5, 1'b1, 1'b1, 1'b0}};
    tbl[1] = '{5'd24, 4'd15, 5'd16, 24'h123456, 24'hFFFFFF, 1'b1, 1'b1, {24'h000000, 1'b1, 1'b1, 1'b0}};
    tbl[2] = '{5'd1,  4'd0,  5'd9,  24'h000000, 24'hABCDEF, 1'b1, 1'b0, {24'h000000, 1'b1, 1'b0, 1'b0}};
    tbl[3] = '{5'd0,  4'd1,  5'd0,  24'h000000, 24'h111111, 1'b1, 1'b1, {24'h000000, 1'b0, 1'b0, 1'b1}};
    tbl[4] = '{5'd25, 4'd1,  5'd16, 24'h777777, 24'h222222, 1'b1, 1'b1, {24'h000000, 1'b0, 1'b0, 1'b1}};
    tbl[5] = '{5'd31, 4'd3,  5'd0,  24'h000000, 24'h333333, 1'b1, 1'b1, {24'h000000, 1'b0, 1'b0, 1'b1}};
    tbl[6] = '{5'd12, 4'd7,  5'd7,  24'h000000, 24'h000001, 1'b0, 1'b1, {24'h000001, 1'b0, 1'b1, 1'b0}};
    tbl[7] = '{5'd12, 4'd8,  5'd23, 24'hFFFFFF, 24'h5A5A5A, 1'b0, 1'b0, {24'h000000, 1'b0, 1'b0, 1'b0}};
    tbl[8] = '{5'd3,  4'd9,  5'd24, 24'h0000FF, 24'hC3C3C3, 1'b1, 1'b0, {24'h000000, 1'b1, 1'b0, 1'b0}};
    tbl[9] = '{5'd17, 4'd5,  5'd8,  24'h00FF00, 24'h3C3C3C, 1'b0, 1'b1, {24'h000000, 1'b0, 1'b1, 1'b0}};

    // Power-on reset
    #2 rst_n = 1'b0;
    #1;
    chk("reset_bus", dut_vec(), 64'h0);
    chk("reset_rsp", rsp_pack(), 27'h0);
    repeat (2) @(negedge clk);
    chk("reset_hold_bus", dut_vec(), 64'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_release", cmd_ready, 1'b1);

    for (int i = 0; i < 10; i++) begin
      do_cmd(tbl[i].n, tbl[i].a, tbl[i].f, tbl[i].wd, tbl[i].r, tbl[i].q, tbl[i].x, got, hold);
      chk($sformatf("tbl%0d_rsp", i), got, tbl[i].rsp);
      chk($sformatf("tbl%0d_rsp_hold", i), hold, tbl[i].rsp);
    end

    for (int i = 0; i < 40; i++) begin
      rn  = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(25, 31)) : 5'($urandom_range(0, 24));
      ra  = 4'($urandom);
      rf  = 5'($urandom);
      rwd = 24'($urandom);
      rr  = 24'($urandom);
      rq  = 1'($urandom);
      rx  = 1'($urandom);
      e   = ref_rsp(rn, rf, rr, rq, rx);
      do_cmd(rn, ra, rf, rwd, rr, rq, rx, got, hold);
      chk($sformatf("rnd%0d_rsp", i), got, e);
      chk($sformatf("rnd%0d_rsp_hold", i), hold, e);
    end

    // Reset in the middle of S1 discards the cycle
    @(negedge clk);
    cmd_valid = 1'b1; cmd_n = 5'd3; cmd_a = 4'd1; cmd_f = 5'd0; cmd_wdata = '0;
    wait_ready(ok);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (22) @(negedge clk);
    chk("pre_reset_s1", camac_s1, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_reset_bus", dut_vec(), 64'h0);
    chk("mid_reset_rsp", rsp_pack(), 27'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_midreset", cmd_ready, 1'b1);
    cnt = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1 || camac_b === 1'b1) cnt++;
    end
    chk("no_activity_after_reset", cnt, 0);
    do_cmd(5'd20, 4'd6, 5'd2, 24'h0, 24'h6B6B6B, 1'b1, 1'b0, got, hold);
    chk("post_reset_rsp", got, {24'h6B6B6B, 1'b1, 1'b0, 1'b0});

    // Back-to-back with cmd_valid held high
    camac_r = 24'h0F0F0F; camac_q = 1'b1; camac_x = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_n = 5'd2; cmd_a = 4'd3; cmd_f = 5'd17; cmd_wdata = 24'h55AA55;
    wait_ready(ok);
    @(negedge clk);
    cmd_n = 5'd7; cmd_a = 4'd4; cmd_f = 5'd1;
    for (int k = 0; k <= 104; k++) begin
      int j;
      j = (k < 52) ? k : k - 52;
      chk($sformatf("b2b k=%0d", k), {camac_b, camac_s1, camac_s2, rsp_valid, cmd_ready},
          {j < T_END, (j >= T_S1) && (j < T_S1 + S1), (j >= T_S2) && (j < T_S2 + S2),
           j == T_END, (j == T_END + 1) || (k >= 103)});
      if (k == 50)  chk("b2b_rsp1", rsp_pack(), {24'h000000, 1'b1, 1'b1, 1'b0});
      if (k == 102) chk("b2b_rsp2", rsp_pack(), {24'h0F0F0F, 1'b1, 1'b1, 1'b0});
      if (k == 52) chk("b2b_n2", camac_n, 24'h000040);
      if (k == 52) cmd_valid = 1'b0;
      if (k < 104) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
